// File: rtl/ifetch_unit.sv
// ============================================================================
//  Module      : ifetch_unit
//  Description : RV32I fetch stage. Owns the PC and drives a 1-cycle-latency
//                synchronous instruction memory. Handles stall, redirect,
//                halt, and a sticky trap on a misaligned redirect target.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ifetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          ADDR_W    = 14,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              redirect,
   input  logic [31:0]       redirect_pc,
   input  logic              halt,
   output logic              imem_en,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   output logic [31:0]       instruction,
   output logic [31:0]       pc,
   output logic [31:0]       pc_plus4,
   output logic              instr_valid,
   output logic              misaligned,
   output logic [31:0]       instr_count
);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic        misaligned_q, misaligned_d;
   logic [31:0] instr_count_q, instr_count_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_BOOT;
         pc_q          <= RESET_PC;
         fetch_pc_q    <= RESET_PC;
         misaligned_q  <= 1'b0;
         instr_count_q <= 32'd0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         fetch_pc_q    <= fetch_pc_d;
         misaligned_q  <= misaligned_d;
         instr_count_q <= instr_count_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      fetch_pc_d    = fetch_pc_q;
      misaligned_d  = misaligned_q;
      instr_count_d = instr_count_q;
      imem_en       = 1'b0;
      imem_addr     = fetch_pc_q[ADDR_W+1:2];
      instr_valid   = 1'b0;

      // Outputs are forced quiet while rst is high; the registers reset at the edge.
      if (!rst) begin
         case (state_q)
            ST_BOOT: begin
               imem_en    = 1'b1;
               pc_d       = fetch_pc_q;
               fetch_pc_d = fetch_pc_q + 32'd4;
               state_d    = ST_RUN;
            end
            ST_RUN: begin
               instr_valid = 1'b1;
               if (halt) begin
                  state_d       = ST_HALT;
                  instr_count_d = instr_count_q + 32'd1;
               end else if (redirect) begin
                  if (redirect_pc[1:0] != 2'b00) begin
                     misaligned_d = 1'b1;
                     state_d      = ST_HALT;
                  end else begin
                     // Target goes straight to memory so a taken branch costs no bubble.
                     imem_en       = 1'b1;
                     imem_addr     = redirect_pc[ADDR_W+1:2];
                     pc_d          = redirect_pc;
                     fetch_pc_d    = redirect_pc + 32'd4;
                     instr_count_d = instr_count_q + 32'd1;
                  end
               end else if (!stall) begin
                  imem_en       = 1'b1;
                  pc_d          = fetch_pc_q;
                  fetch_pc_d    = fetch_pc_q + 32'd4;
                  instr_count_d = instr_count_q + 32'd1;
               end
            end
            ST_HALT: begin
            end
            default: begin
               state_d = ST_BOOT;
            end
         endcase
      end
   end

   assign instruction = instr_valid ? imem_rdata : NOP_INSTR;
   assign pc          = pc_q;
   assign pc_plus4    = pc_q + 32'd4;
   assign misaligned  = misaligned_q;
   assign instr_count = instr_count_q;

endmodule

`default_nettype wire

// File: tb/tb_ifetch_unit.sv
// ============================================================================
//  Module      : tb_ifetch_unit
//  Description : Self-checking bench for ifetch_unit with a reference fetch
//                model, a word-indexed memory model and an output scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ifetch_unit;

   localparam int          ADDR_W    = 14;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] BASE_WORD = 32'h0010_0093;

   localparam logic [1:0] M_BOOT = 2'd0;
   localparam logic [1:0] M_RUN  = 2'd1;
   localparam logic [1:0] M_HALT = 2'd2;

   logic              clk = 1'b0;
   logic              rst;
   logic              stall;
   logic              redirect;
   logic [31:0]       redirect_pc;
   logic              halt;
   logic              imem_en;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_rdata;
   logic [31:0]       instruction;
   logic [31:0]       pc;
   logic [31:0]       pc_plus4;
   logic              instr_valid;
   logic              misaligned;
   logic [31:0]       instr_count;

   ifetch_unit #(
      .RESET_PC  (RESET_PC),
      .ADDR_W    (ADDR_W),
      .NOP_INSTR (NOP_INSTR)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halt        (halt),
      .imem_en     (imem_en),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .instruction (instruction),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .instr_valid (instr_valid),
      .misaligned  (misaligned),
      .instr_count (instr_count)
   );

   always #5 clk = ~clk;

   // Memory word k holds BASE_WORD + k; rdata holds while imem_en is low.
   always @(posedge clk) begin
      if (imem_en) imem_rdata <= BASE_WORD + 32'(imem_addr);
   end

   int checks = 0;
   int errors = 0;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", tag, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [31:0] pc;
      logic [31:0] cnt;
   } sb_t;

   sb_t sb_q[$];
   sb_t sb_e;

   // Every valid cycle must match the next scoreboard entry.
   always @(negedge clk) begin
      if (instr_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            check_val("sb_underflow", 32'(sb_q.size()), 32'd1);
         end else begin
            sb_e = sb_q.pop_front();
            check_val("sb_pc", pc, sb_e.pc);
            check_val("sb_instr", instruction, BASE_WORD + {18'd0, sb_e.pc[15:2]});
            check_val("sb_pc_plus4", pc_plus4, sb_e.pc + 32'd4);
            check_val("sb_count", instr_count, sb_e.cnt);
         end
      end
   end

   logic [1:0]  m_state = M_BOOT;
   logic [31:0] m_pc    = RESET_PC;
   logic [31:0] m_fetch = RESET_PC;
   logic        m_mis   = 1'b0;
   logic [31:0] m_cnt   = 32'd0;

   task automatic step(input logic s, input logic rd, input logic [31:0] rpc,
                       input logic h, input logic r);
      logic        e_valid;
      logic        e_en;
      logic [31:0] e_addr;
      sb_t         ent;
      stall = s; redirect = rd; redirect_pc = rpc; halt = h; rst = r;

      e_valid = !r && (m_state == M_RUN);
      e_addr  = m_fetch;
      e_en    = 1'b0;
      if (!r && m_state == M_BOOT) e_en = 1'b1;
      if (e_valid && !h) begin
         if (rd) begin
            e_en   = (rpc[1:0] == 2'b00);
            e_addr = rpc;
         end else begin
            e_en = !s;
         end
      end
      if (e_valid) begin
         ent.pc  = m_pc;
         ent.cnt = m_cnt;
         sb_q.push_back(ent);
      end

      @(negedge clk);
      check_val("instr_valid", {31'd0, instr_valid}, {31'd0, e_valid});
      check_val("imem_en", {31'd0, imem_en}, {31'd0, e_en});
      check_val("misaligned", {31'd0, misaligned}, {31'd0, m_mis});
      check_val("pc", pc, m_pc);
      check_val("instr_count", instr_count, m_cnt);
      if (!e_valid) check_val("nop", instruction, NOP_INSTR);
      if (e_en) check_val("imem_addr", 32'(imem_addr), {18'd0, e_addr[15:2]});

      @(posedge clk);
      if (r) begin
         m_state = M_BOOT; m_pc = RESET_PC; m_fetch = RESET_PC; m_mis = 1'b0; m_cnt = 32'd0;
      end else if (m_state == M_BOOT) begin
         m_pc = m_fetch; m_fetch = m_fetch + 32'd4; m_state = M_RUN;
      end else if (m_state == M_RUN) begin
         if (h) begin
            m_state = M_HALT; m_cnt = m_cnt + 32'd1;
         end else if (rd) begin
            if (rpc[1:0] != 2'b00) begin
               m_mis = 1'b1; m_state = M_HALT;
            end else begin
               m_pc = rpc; m_fetch = rpc + 32'd4; m_cnt = m_cnt + 32'd1;
            end
         end else if (!s) begin
            m_pc = m_fetch; m_fetch = m_fetch + 32'd4; m_cnt = m_cnt + 32'd1;
         end
      end
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; halt = 1'b0;

      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
      run(3);                                           // BOOT, pc 0, pc 4
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0); // stall at pc 8
      run(2);                                           // pc 8, pc 12
      step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);              // halt at pc 0x10
      run(2);

      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
      run(2);                                           // BOOT, pc 0
      step(1'b1, 1'b1, 32'h0000_0040, 1'b0, 1'b0);      // redirect beats stall at pc 4
      run(1);                                           // pc 0x40
      step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);      // pc 0x44
      run(9);                                           // 0xFFFFFFFC wraps to 0 .. 0x1C
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);              // rst mid-run at pc 0x20

      run(2);                                           // BOOT, pc 0
      step(1'b0, 1'b1, 32'h0000_0042, 1'b0, 1'b0);      // misaligned target at pc 4
      run(3);
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
      run(2);

      check_val("sb_left", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
